// File: rtl/instr_decode_stage_pkg.sv
// Shared ALU/ISA definitions: ALU opcodes, RV32 opcode/func3/func7 fields,
// M-extension operation encodings and the decoded-instruction record.
package instr_decode_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu_op;
    logic [2:0]  md_op;
    logic        is_md;
    logic [31:0] imm;
    logic        use_imm;
    logic        illegal;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0, alu_op: ALU_NOP, md_op: 3'd0,
    is_md: 1'b0, imm: 32'd0, use_imm: 1'b0, illegal: 1'b0
  };

  // Buffer occupancy; bit 0 = main entry valid, bit 1 = skid entry valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

  // ALU op selected by func3 for the base (func7 = 0) integer group.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/instr_decode_stage_alu_decode.sv
// Combinational RV32I OP/OP-IMM (and optional RV32M) decoder.
module rv_alu_decode
  import instr_decode_stage_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Field extraction, legality check, then squash of control fields when illegal.
  always_comb begin
    dec         = DEC_RESET;
    dec.rd      = instr[11:7];
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        case (f7)
          F7_BASE: dec.alu_op = base_alu(f3);
          F7_ALT: begin
            if (f3 == F3_ADD_SUB)  dec.alu_op  = ALU_SUB;
            else if (f3 == F3_SR)  dec.alu_op  = ALU_SRA;
            else                   dec.illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M != 0) begin
              dec.is_md  = 1'b1;
              dec.md_op  = f3;
              dec.alu_op = ALU_NOP;
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec.use_imm = 1'b1;
        dec.imm     = {{20{instr[31]}}, instr[31:20]};
        dec.alu_op  = base_alu(f3);
        if (f3 == F3_SLL && f7 != F7_BASE) begin
          dec.illegal = 1'b1;
        end else if (f3 == F3_SR) begin
          if (f7 == F7_ALT)        dec.alu_op  = ALU_SRA;
          else if (f7 != F7_BASE)  dec.illegal = 1'b1;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_op  = ALU_NOP;
      dec.md_op   = 3'd0;
      dec.is_md   = 1'b0;
      dec.imm     = 32'd0;
      dec.use_imm = 1'b0;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes on the input side and holds results in a 2-entry
// (main + skid) buffer so in_ready can come straight from a flop.
//
// state     | meaning
// ----------+-----------------------------------------------
// OCC_EMPTY | nothing buffered, out_valid=0, in_ready=1
// OCC_ONE   | main entry presented, skid free, in_ready=1
// OCC_TWO   | main presented and skid holding, in_ready=0
module instr_decode_stage
  import instr_decode_stage_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [3:0]       out_alu_op,
  output logic [2:0]       out_md_op,
  output logic             out_is_md,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t            in_dec;
  dec_t            main_dec, skid_dec;
  logic [PC_W-1:0] main_pc, skid_pc;
  occ_e            state_q, state_d;
  logic            accept, deq;
  logic            ld_main_in, ld_main_skid, ld_skid_in;

  rv_alu_decode #(.ENABLE_M(ENABLE_M)) u_alu_decode (
    .instr (in_instr),
    .dec   (in_dec)
  );

  // Handshake flags come directly from the occupancy flop bits.
  assign out_valid = state_q[0];
  assign in_ready  = ~state_q[1];
  assign accept    = in_valid & in_ready;
  assign deq       = out_valid & out_ready;

  // Occupancy state register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy from accept/dequeue; flush drops both entries and any input.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (accept) state_d = OCC_ONE;
        OCC_ONE: begin
          if (accept && !deq)      state_d = OCC_TWO;
          else if (!accept && deq) state_d = OCC_EMPTY;
        end
        OCC_TWO:   if (deq) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // Datapath load strobes; under flush the loaded data is never presented.
  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    case (state_q)
      OCC_EMPTY: ld_main_in = accept;
      OCC_ONE: begin
        ld_main_in = accept & deq;
        ld_skid_in = accept & ~deq;
      end
      OCC_TWO:   ld_main_skid = deq;
      default:   ld_main_in = 1'b0;
    endcase
  end

  // Main entry: refilled from the input, or promoted from skid, only on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_dec <= DEC_RESET;
      main_pc  <= '0;
    end else if (ld_main_in) begin
      main_dec <= in_dec;
      main_pc  <= in_pc;
    end else if (ld_main_skid) begin
      main_dec <= skid_dec;
      main_pc  <= skid_pc;
    end
  end

  // Skid entry catches the input while the main entry is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_dec <= DEC_RESET;
      skid_pc  <= '0;
    end else if (ld_skid_in) begin
      skid_dec <= in_dec;
      skid_pc  <= in_pc;
    end
  end

  // Saturating count of illegal instructions handed downstream; flush does not touch it.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_cnt <= '0;
    else if (deq && main_dec.illegal && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign out_pc      = main_pc;
  assign out_rd      = main_dec.rd;
  assign out_rs1     = main_dec.rs1;
  assign out_rs2     = main_dec.rs2;
  assign out_alu_op  = main_dec.alu_op;
  assign out_md_op   = main_dec.md_op;
  assign out_is_md   = main_dec.is_md;
  assign out_imm     = main_dec.imm;
  assign out_use_imm = main_dec.use_imm;
  assign out_illegal = main_dec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: three instances (M off, M on, 2-bit counter)
// checked every cycle against a queue model plus directed literal checks.
module tb_instr_decode_stage;
  import instr_decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_ir, a_ov, a_ismd, a_uimm, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [3:0]  a_alu;
  logic [2:0]  a_md;
  logic [15:0] a_cnt;

  logic        m_ir, m_ov, m_ismd, m_uimm, m_ill;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [3:0]  m_alu;
  logic [2:0]  m_md;
  logic [15:0] m_cnt;

  logic        s_ir, s_ov, s_ismd, s_uimm, s_ill;
  logic [31:0] s_pc, s_imm;
  logic [4:0]  s_rd, s_rs1, s_rs2;
  logic [3:0]  s_alu;
  logic [2:0]  s_md;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  instr_decode_stage #(.PC_W(32), .ENABLE_M(0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_ov), .out_ready(out_ready),
    .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_alu_op(a_alu), .out_md_op(a_md), .out_is_md(a_ismd), .out_imm(a_imm),
    .out_use_imm(a_uimm), .out_illegal(a_ill), .illegal_cnt(a_cnt));

  instr_decode_stage #(.PC_W(32), .ENABLE_M(1), .CNT_W(16)) u_dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_ir),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_ov), .out_ready(out_ready),
    .out_pc(m_pc), .out_rd(m_rd), .out_rs1(m_rs1), .out_rs2(m_rs2),
    .out_alu_op(m_alu), .out_md_op(m_md), .out_is_md(m_ismd), .out_imm(m_imm),
    .out_use_imm(m_uimm), .out_illegal(m_ill), .illegal_cnt(m_cnt));

  instr_decode_stage #(.PC_W(32), .ENABLE_M(0), .CNT_W(2)) u_dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_ir),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_ov), .out_ready(out_ready),
    .out_pc(s_pc), .out_rd(s_rd), .out_rs1(s_rs1), .out_rs2(s_rs2),
    .out_alu_op(s_alu), .out_md_op(s_md), .out_is_md(s_ismd), .out_imm(s_imm),
    .out_use_imm(s_uimm), .out_illegal(s_ill), .illegal_cnt(s_cnt));

  typedef struct packed {
    logic [3:0]  alu;
    logic [2:0]  md;
    logic        is_md;
    logic [31:0] imm;
    logic        use_imm;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   cnt0 = 0, cnt1 = 0;
  int   n_chk = 0, n_pass = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_dec(input logic [31:0] i, input bit en_m);
    exp_t r;
    logic [3:0] base [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    base = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    r = '{alu: ALU_NOP, md: 3'd0, is_md: 1'b0, imm: 32'd0, use_imm: 1'b0, ill: 1'b1};
    if (op == 7'h33) begin
      if (f7 == 7'h00) begin r.alu = base[f3]; r.ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin r.alu = ALU_SUB; r.ill = 1'b0; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin r.alu = ALU_SRA; r.ill = 1'b0; end
      else if (f7 == 7'h01 && en_m) begin r.is_md = 1'b1; r.md = f3; r.ill = 1'b0; end
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) begin r.alu = ALU_SLL; r.ill = 1'b0; end
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00) begin r.alu = ALU_SRL; r.ill = 1'b0; end
        else if (f7 == 7'h20) begin r.alu = ALU_SRA; r.ill = 1'b0; end
      end else begin
        r.alu = base[f3]; r.ill = 1'b0;
      end
      if (!r.ill) begin
        r.use_imm = 1'b1;
        r.imm = {{20{i[31]}}, i[31:20]};
      end
    end
    return r;
  endfunction

  task automatic cmp_inst(input string nm, input bit en_m, input logic ov, input logic ir,
                          input logic [88:0] fields, input logic [15:0] cnt, input int ecnt);
    exp_t e;
    chk({nm, ".out_valid"}, {95'd0, ov}, {95'd0, q.size() > 0});
    chk({nm, ".in_ready"}, {95'd0, ir}, {95'd0, q.size() < 2});
    chk({nm, ".illegal_cnt"}, {80'd0, cnt}, 96'(ecnt));
    if (q.size() > 0) begin
      e = ref_dec(q[0].instr, en_m);
      chk({nm, ".fields"}, {7'd0, fields},
          {7'd0, q[0].pc, q[0].instr[11:7], q[0].instr[19:15], q[0].instr[24:20],
           e.alu, e.md, e.is_md, e.imm, e.use_imm, e.ill});
    end
  endtask

  // Model: one transfer out and one accept per edge, flush drops everything.
  always @(posedge clk) begin : model
    exp_t e;
    bit acc, dq;
    if (rst) begin
      q.delete(); cnt0 = 0; cnt1 = 0; chk_en = 1'b1;
    end else begin
      dq  = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2);
      if (dq) begin
        e = ref_dec(q[0].instr, 1'b0);
        if (e.ill && cnt0 < 65535) cnt0++;
        e = ref_dec(q[0].instr, 1'b1);
        if (e.ill && cnt1 < 65535) cnt1++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc) q.push_back('{instr: in_instr, pc: in_pc});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("dut", 1'b0, a_ov, a_ir,
        {a_pc, a_rd, a_rs1, a_rs2, a_alu, a_md, a_ismd, a_imm, a_uimm, a_ill}, a_cnt, cnt0);
      cmp_inst("dut_m", 1'b1, m_ov, m_ir,
        {m_pc, m_rd, m_rs1, m_rs2, m_alu, m_md, m_ismd, m_imm, m_uimm, m_ill}, m_cnt, cnt1);
      cmp_inst("dut_s", 1'b0, s_ov, s_ir,
        {s_pc, s_rd, s_rs1, s_rs2, s_alu, s_md, s_ismd, s_imm, s_uimm, s_ill},
        {14'd0, s_cnt}, (cnt0 > 3) ? 3 : cnt0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the M-off instance takes it.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    bit took;
    int guard;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    took = 1'b0; guard = 0;
    while (!took && guard < 20) begin
      took = a_ir;
      cyc();
      guard++;
    end
    if (!took) begin
      n_chk++;
      $display("FAIL send_timeout: instr %0h not accepted within 20 cycles", instr);
    end
    in_valid = 1'b0;
  endtask

  logic [31:0] stream [13] = '{
    32'h40208133, 32'h4062D233, 32'h009433B3, 32'h00309093, 32'h40309093,
    32'h4020D093, 32'h0220D093, 32'h40209133, 32'h0220D1B3, 32'h0000A083,
    32'hFF01F113, 32'h7FF1C113, 32'h04208133};

  int saved_cnt;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'd0; in_pc = 32'd0;

    // Pin the reference decoder with hand-derived values.
    chk("ref.add_alu", 96'(ref_dec(32'h002081B3, 1'b0).alu), 96'(ALU_ADD));
    chk("ref.addi_imm", 96'(ref_dec(32'hFFF00293, 1'b0).imm), 96'hFFFFFFFF);
    chk("ref.sra_alu", 96'(ref_dec(32'h4062D233, 1'b0).alu), 96'(ALU_SRA));
    chk("ref.andi_imm", 96'(ref_dec(32'hFF01F113, 1'b0).imm), 96'hFFFFFFF0);
    chk("ref.slli_bad", 96'(ref_dec(32'h40309093, 1'b0).ill), 96'd1);
    chk("ref.mul_md", 96'(ref_dec(32'h023100B3, 1'b1).is_md), 96'd1);

    repeat (3) cyc();
    chk("reset.out_valid", 96'(a_ov), 96'd0);
    chk("reset.in_ready", 96'(a_ir), 96'd1);
    chk("reset.alu_op", 96'(a_alu), 96'(ALU_NOP));
    chk("reset.data", {a_pc, a_rd, a_rs1, a_rs2, a_imm}, 96'd0);
    rst = 1'b0;

    // ADD x3,x1,x2 at 0x100, one-cycle latency
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
    cyc();
    in_valid = 1'b0;
    chk("add.valid", 96'(a_ov), 96'd1);
    chk("add.alu", 96'(a_alu), 96'(ALU_ADD));
    chk("add.regs", {81'd0, a_rd, a_rs1, a_rs2}, {81'd0, 5'd3, 5'd1, 5'd2});
    chk("add.pc_ill", {a_pc, a_ill}, {32'h100, 1'b0});
    cyc();

    // MUL x1,x2,x3 on both M configurations
    in_valid = 1'b1; in_instr = 32'h023100B3; in_pc = 32'h104;
    cyc();
    in_valid = 1'b0;
    chk("mul.m0_illegal", 96'(a_ill), 96'd1);
    chk("mul.m1_md", {m_ismd, m_md, m_ill}, {1'b1, 3'b000, 1'b0});
    chk("mul.cnt_before", 96'(a_cnt), 96'd0);
    cyc();
    chk("mul.cnt_after", 96'(a_cnt), 96'd1);
    chk("mul.m1_cnt", 96'(m_cnt), 96'd0);

    // ADDI x5,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h108;
    cyc();
    in_valid = 1'b0;
    chk("addi.imm", {a_uimm, a_imm, a_alu}, {1'b1, 32'hFFFFFFFF, ALU_ADD});
    cyc();

    // Mixed stream with intermittent backpressure
    for (int i = 0; i < 13; i++) begin
      out_ready = (i % 3) != 0;
      send(stream[i], 32'h200 + 32'(i * 4));
    end
    out_ready = 1'b1;
    repeat (4) cyc();

    // Three back-to-back with output stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h300; cyc();
    in_instr = 32'h40208133; in_pc = 32'h304; cyc();
    in_instr = 32'h009433B3; in_pc = 32'h308;
    chk("stall.in_ready_drop", 96'(a_ir), 96'd0);
    repeat (2) cyc();
    chk("stall.hold_pc", 96'(a_pc), 96'h300);
    out_ready = 1'b1;
    send(32'h009433B3, 32'h308);
    repeat (4) cyc();

    // Flush with two buffered entries and a same-cycle input
    out_ready = 1'b0;
    send(32'h00000000, 32'h400);
    send(32'hFFFFFFFF, 32'h404);
    saved_cnt = cnt0;
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h408;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 96'(a_ov), 96'd0);
    chk("flush.in_ready", 96'(a_ir), 96'd1);
    chk("flush.cnt_kept", 96'(a_cnt), 96'(saved_cnt));
    out_ready = 1'b1;
    repeat (2) cyc();

    // Reset in the middle of a stall, together with flush and input
    out_ready = 1'b0;
    send(32'h0000A083, 32'h500);
    send(32'h4062D233, 32'h504);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h002081B3;
    cyc();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("rst.out_valid", 96'(a_ov), 96'd0);
    chk("rst.in_ready", 96'(a_ir), 96'd1);
    chk("rst.cnt", 96'(a_cnt), 96'd0);
    chk("rst.alu_op", 96'(a_alu), 96'(ALU_NOP));
    chk("rst.data", {a_pc, a_rd, a_rs1, a_rs2, a_imm}, 96'd0);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning program-counter width carried alongside each instruction.
REQ-002 SHALL have parameter ENABLE_M, default 0, meaning that when 1, RV32M multiply/divide R-type instructions are decoded; when 0 they are flagged illegal.
REQ-003 SHALL have parameter CNT_W, default 16, meaning illegal-instruction counter width.
REQ-004 SHALL have port clk, input, 1, the single clock for the block.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, which discards all buffered instructions.
REQ-007 SHALL have port in_valid/in_ready, input/output, 1 each, upstream handshake.
REQ-008 SHALL have port in_instr, input, 32, instruction word.
REQ-009 SHALL have port in_pc, input, PC_W, instruction address.
REQ-010 SHALL have port out_valid/out_ready, output/input, 1 each, downstream handshake.
REQ-011 SHALL have port out_pc, output, PC_W, address of the presented instruction.
REQ-012 SHALL have ports out_rd, out_rs1, out_rs2, output, 5 each, register fields [11:7], [19:15], [24:20].
REQ-013 SHALL have port out_alu_op, output, 4, ALU opcode from the shared ALU opcode definitions.
REQ-014 SHALL have ports out_md_op and out_is_md, output, 3 and 1, M-extension operation (= func3) and its enable.
REQ-015 SHALL have ports out_imm and out_use_imm, output, 32 and 1, sign-extended I-immediate and its operand select.
REQ-016 SHALL have port out_illegal, output, 1, marking the presented instruction as undecodable.
REQ-017 SHALL have port illegal_cnt, output, CNT_W, count of illegal instructions accepted downstream.

Function
REQ-018 SHALL decode opcode 0110011 (OP) and 0010011 (OP-IMM); every other opcode SHALL set out_illegal=1 and out_alu_op=ALU_NOP.
REQ-019 OP: func7=0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by func3; func7=0100000 is legal only with func3 000 (SUB) or 101 (SRA); any other func7 is illegal.
REQ-020 OP with func7=0000001 SHALL set out_is_md=1, out_md_op=func3, out_alu_op=ALU_NOP when ENABLE_M=1, and SHALL be illegal when ENABLE_M=0.
REQ-021 OP-IMM SHALL set out_use_imm=1 and out_imm={{20{instr[31]}},instr[31:20]}; SLLI requires func7=0000000, SRLI/SRAI require func7 0000000/0100000 respectively, otherwise illegal; func3=000 maps to ADD.
REQ-022 Illegal instructions SHALL force out_is_md=0, out_use_imm=0, out_alu_op=ALU_NOP; register fields and pc still pass through.
REQ-023 Decode SHALL be performed on the input side and registered; latency in_valid&in_ready to out_valid SHALL be exactly 1 cycle when the output is empty.
REQ-024 Storage SHALL be a 2-entry skid buffer (main + skid); in_ready SHALL be registered and equal to "skid entry empty".
REQ-025 When out_valid=1 and out_ready=0, the presented entry and all out_* fields SHALL remain stable.
REQ-026 Simultaneous accept and output transfer with one entry held SHALL keep occupancy at 1 with the new entry presented next cycle; order SHALL be preserved.
REQ-027 flush SHALL empty both entries on the next edge, dropping any same-cycle input; in_ready=1 and out_valid=0 afterwards.
REQ-028 illegal_cnt SHALL increment on out_valid&out_ready&out_illegal, SHALL saturate at all-ones, and SHALL be unaffected by flush.

Reset
REQ-029 On rst, out_valid=0, in_ready=1, buffers empty, illegal_cnt=0, and all data outputs 0 except out_alu_op=ALU_NOP.
REQ-030 rst SHALL take priority over flush and any handshake in the same cycle, including mid-stall.

Structure
REQ-031 ALU opcode constants (including ALU_NOP) and RV32 opcode/func3/func7 constants SHALL live in the shared ALU/ISA include; M-op encodings added there.
REQ-032 Combinational decode SHALL be one sub-module, rv_alu_decode, instantiated once ahead of the skid buffer.

Verification
REQ-033 ADD x3,x1,x2 (0x002081B3), pc 0x100, out_ready=1 -> next cycle out_valid=1, ALU_ADD, rd=3, rs1=1, rs2=2, illegal=0.
REQ-034 ADDI x5,x0,-1 (0xFFF00293) -> out_use_imm=1, out_imm=0xFFFFFFFF, ALU_ADD.
REQ-035 MUL x1,x2,x3 (0x023100B3): ENABLE_M=1 -> is_md=1, md_op=000; ENABLE_M=0 -> illegal=1, illegal_cnt 0->1.
REQ-036 Three back-to-back instructions with out_ready=0 -> in_ready drops after two accepted; release out_ready -> all delivered in order, none lost or duplicated.
REQ-037 Two entries buffered, assert flush -> next cycle out_valid=0, in_ready=1; illegal_cnt unchanged; rst mid-stall -> reset values of REQ-029.
